// File: rtl/nf10_nic_input_arbiter.sv
// Packet-granular round-robin merge of up to eight AXI4-Stream slaves into one
// master stream; the output and every tready come straight from flops.
module nf10_nic_input_arbiter #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_INPUTS           = 5
) (
  input  logic                                 axi_aclk,
  input  logic                                 axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_0_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_0_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_0_tuser,
  input  logic                                 s_axis_0_tvalid,
  output logic                                 s_axis_0_tready,
  input  logic                                 s_axis_0_tlast,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_1_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_1_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_1_tuser,
  input  logic                                 s_axis_1_tvalid,
  output logic                                 s_axis_1_tready,
  input  logic                                 s_axis_1_tlast,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_2_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_2_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_2_tuser,
  input  logic                                 s_axis_2_tvalid,
  output logic                                 s_axis_2_tready,
  input  logic                                 s_axis_2_tlast,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_3_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_3_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_3_tuser,
  input  logic                                 s_axis_3_tvalid,
  output logic                                 s_axis_3_tready,
  input  logic                                 s_axis_3_tlast,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_4_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_4_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_4_tuser,
  input  logic                                 s_axis_4_tvalid,
  output logic                                 s_axis_4_tready,
  input  logic                                 s_axis_4_tlast,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_5_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_5_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_5_tuser,
  input  logic                                 s_axis_5_tvalid,
  output logic                                 s_axis_5_tready,
  input  logic                                 s_axis_5_tlast,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_6_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_6_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_6_tuser,
  input  logic                                 s_axis_6_tvalid,
  output logic                                 s_axis_6_tready,
  input  logic                                 s_axis_6_tlast,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_7_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_7_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_7_tuser,
  input  logic                                 s_axis_7_tvalid,
  output logic                                 s_axis_7_tready,
  input  logic                                 s_axis_7_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast
);

  localparam int MAXP = 8;
  localparam int DW   = C_S_AXIS_DATA_WIDTH;
  localparam int SW   = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW   = C_S_AXIS_TUSER_WIDTH;
  // Port sets at or above NUM_INPUTS exist physically but never request.
  localparam logic [MAXP-1:0] PORT_MASK = 8'((16'd1 << NUM_INPUTS) - 16'd1);

  typedef struct packed {
    logic [DW-1:0] tdata;
    logic [SW-1:0] tstrb;
    logic [UW-1:0] tuser;
    logic          tlast;
  } beat_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_PKT = 1'b1} state_t;

  beat_t           w_in [MAXP];
  logic [MAXP-1:0] w_in_valid;
  logic [MAXP-1:0] w_req;
  beat_t           w_beat;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_cnt_nxt;
  logic            w_found;
  logic [2:0]      w_pick;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_grant;
  logic [2:0]      w_grant_nxt;
  logic [2:0]      r_rr_ptr;
  logic [2:0]      w_rr_ptr_nxt;
  logic [MAXP-1:0] r_tready;
  logic [MAXP-1:0] w_tready_nxt;
  beat_t           r_head;
  beat_t           r_tail;
  logic            r_head_v;
  logic            r_tail_v;

  assign w_in[0] = {s_axis_0_tdata, s_axis_0_tstrb, s_axis_0_tuser, s_axis_0_tlast};
  assign w_in[1] = {s_axis_1_tdata, s_axis_1_tstrb, s_axis_1_tuser, s_axis_1_tlast};
  assign w_in[2] = {s_axis_2_tdata, s_axis_2_tstrb, s_axis_2_tuser, s_axis_2_tlast};
  assign w_in[3] = {s_axis_3_tdata, s_axis_3_tstrb, s_axis_3_tuser, s_axis_3_tlast};
  assign w_in[4] = {s_axis_4_tdata, s_axis_4_tstrb, s_axis_4_tuser, s_axis_4_tlast};
  assign w_in[5] = {s_axis_5_tdata, s_axis_5_tstrb, s_axis_5_tuser, s_axis_5_tlast};
  assign w_in[6] = {s_axis_6_tdata, s_axis_6_tstrb, s_axis_6_tuser, s_axis_6_tlast};
  assign w_in[7] = {s_axis_7_tdata, s_axis_7_tstrb, s_axis_7_tuser, s_axis_7_tlast};

  assign w_in_valid = {s_axis_7_tvalid, s_axis_6_tvalid, s_axis_5_tvalid, s_axis_4_tvalid,
                       s_axis_3_tvalid, s_axis_2_tvalid, s_axis_1_tvalid, s_axis_0_tvalid};
  assign {s_axis_7_tready, s_axis_6_tready, s_axis_5_tready, s_axis_4_tready,
          s_axis_3_tready, s_axis_2_tready, s_axis_1_tready, s_axis_0_tready} = r_tready;

  assign w_req     = w_in_valid & PORT_MASK;
  assign w_beat    = w_in[r_grant];
  assign w_push    = (r_state == ST_PKT) & w_in_valid[r_grant] & r_tready[r_grant];
  assign w_pop     = r_head_v & m_axis_tready;
  assign w_cnt_nxt = {1'b0, r_head_v} + {1'b0, r_tail_v} + {1'b0, w_push} - {1'b0, w_pop};

  assign m_axis_tdata  = r_head.tdata;
  assign m_axis_tstrb  = r_head.tstrb;
  assign m_axis_tuser  = r_head.tuser;
  assign m_axis_tlast  = r_head.tlast;
  assign m_axis_tvalid = r_head_v;

  // First requester at or after rr_ptr, wrapping modulo NUM_INPUTS.
  always_comb begin : rr_search
    logic [3:0] idx;
    idx     = 4'd0;
    w_found = 1'b0;
    w_pick  = 3'd0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      idx = {1'b0, r_rr_ptr} + 4'(i);
      if (idx >= 4'(NUM_INPUTS)) begin
        idx = idx - 4'(NUM_INPUTS);
      end else begin
        idx = idx;
      end
      if (!w_found && w_req[idx[2:0]]) begin
        w_found = 1'b1;
        w_pick  = idx[2:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Arbitration FSM next state: hold the grant until the tlast beat is taken.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_PKT;
          w_grant_nxt = w_pick;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PKT: begin
        if (w_push && w_beat.tlast) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = (r_grant == 3'(NUM_INPUTS - 1)) ? 3'd0 : r_grant + 3'd1;
        end else begin
          w_state_nxt = ST_PKT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // tready looks one cycle ahead so a registered ready never overfills the skid.
  always_comb begin
    w_tready_nxt = '0;
    if (w_state_nxt == ST_PKT && w_cnt_nxt != 2'd2) begin
      w_tready_nxt[w_grant_nxt] = 1'b1;
    end else begin
      w_tready_nxt = '0;
    end
  end

  // Arbitration state, grant, pointer and slave ready registers.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state  <= ST_IDLE;
      r_grant  <= 3'd0;
      r_rr_ptr <= 3'd0;
      r_tready <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_tready <= w_tready_nxt;
    end
  end

  // Two-entry skid: head drives the master port, tail only fills behind a stalled head.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_head_v <= 1'b0;
      r_tail_v <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_tail_v) begin
            r_head <= r_tail;
            r_tail <= w_beat;
          end else begin
            r_head <= w_beat;
          end
        end
        2'b10: begin
          if (!r_head_v) begin
            r_head   <= w_beat;
            r_head_v <= 1'b1;
          end else begin
            r_tail   <= w_beat;
            r_tail_v <= 1'b1;
          end
        end
        2'b01: begin
          r_head   <= r_tail;
          r_head_v <= r_tail_v;
          r_tail_v <= 1'b0;
        end
        default: begin
          r_head_v <= r_head_v;
        end
      endcase
    end
  end

endmodule
